cr_kme_fifo_param: RTL

//  Parametrised show-ahead FIFO with built-in storage, used for KME datapath buffering.

---
 rtl/cr_kme_fifo_pkg.sv | 16 +
 rtl/cr_kme_fifo_ptr.sv | 46 ++++
 rtl/cr_kme_fifo_param.sv | 136 +++++++++++++
 3 files changed

// File: rtl/cr_kme_fifo_pkg.sv
// Shared helpers for the KME parametrised FIFO.
//   cr_kme_fifo_cw(depth) : width of an occupancy count that can hold 0..depth
//   cr_kme_fifo_pw(depth) : width of a read/write pointer addressing 0..depth-1
// No ports; imported by cr_kme_fifo_ptr and cr_kme_fifo_param.
package cr_kme_fifo_pkg;

  function automatic int cr_kme_fifo_cw(input int depth);
    return $clog2(depth + 1);
  endfunction

  // A single-entry pointer would have zero width; keep at least one bit.
  function automatic int cr_kme_fifo_pw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/cr_kme_fifo_ptr.sv
// Modulo-DEPTH pointer used for the FIFO write and read positions.
// DEPTH need not be a power of two: the pointer wraps explicitly at DEPTH-1.
// Ports:
//   clk   in   clock
//   rst   in   synchronous reset, active-high, pointer -> 0
//   clear in   synchronous flush, pointer -> 0 (lower priority than rst)
//   inc   in   advance the pointer by one position
//   ptr   out  current pointer value (PW bits)
module cr_kme_fifo_ptr
  import cr_kme_fifo_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = cr_kme_fifo_pw(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  logic [PW-1:0] ptr_reg;
  logic [PW-1:0] ptr_next;

  always_comb begin
    ptr_next = ptr_reg;
    if (inc) begin
      if (ptr_reg == PW'(DEPTH - 1)) begin
        ptr_next = '0;
      end else begin
        ptr_next = ptr_reg + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

  assign ptr = ptr_reg;

endmodule

// File: rtl/cr_kme_fifo_param.sv
// Parametrised show-ahead FIFO with built-in storage for KME datapath buffering.
// Producer side obeys fifo_in_stall; consumer side uses fifo_out_valid / fifo_out_ack.
// Optional feature: define CR_KME_FIFO_WMARK_EN to add the occupancy
// high-watermark (max_used output, max_used_clr input).
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   clear                     synchronous flush (empties FIFO, no pulses)
//   fifo_in, fifo_in_valid    write data / write request
//   fifo_in_stall_override    force fifo_in_stall high
//   fifo_in_stall             producer must hold off
//   fifo_out, fifo_out_valid  head entry (0 when empty) / non-empty flag
//   fifo_out_ack              consumer pops the head this cycle
//   used_slots, free_slots    occupancy and remaining space
//   fifo_overflow             1-cycle pulse: write dropped because full
//   fifo_underflow            1-cycle pulse: ack while empty
//   max_used, max_used_clr    watermark and its reload (CR_KME_FIFO_WMARK_EN only)
module cr_kme_fifo_param
  import cr_kme_fifo_pkg::*;
#(
  parameter int WIDTH        = 611,
  parameter int DEPTH        = 4,
  parameter int STALL_THRESH = 0,
  localparam int CW = cr_kme_fifo_cw(DEPTH),
  localparam int PW = cr_kme_fifo_pw(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [WIDTH-1:0] fifo_in,
  input  logic             fifo_in_valid,
  input  logic             fifo_in_stall_override,
  output logic             fifo_in_stall,
  output logic [WIDTH-1:0] fifo_out,
  output logic             fifo_out_valid,
  input  logic             fifo_out_ack,
  output logic [CW-1:0]    used_slots,
  output logic [CW-1:0]    free_slots,
  output logic             fifo_overflow,
  output logic             fifo_underflow
`ifdef CR_KME_FIFO_WMARK_EN
  ,
  output logic [CW-1:0]    max_used,
  input  logic             max_used_clr
`endif
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [CW-1:0]    used_reg;
  logic [CW-1:0]    used_next;
  logic             overflow_reg;
  logic             underflow_reg;
  logic             full;
  logic             empty;
  logic             ren;
  logic             wen_ok;

  assign full   = (used_reg == CW'(DEPTH));
  assign empty  = (used_reg == '0);
  assign ren    = !empty && fifo_out_ack;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign wen_ok = fifo_in_valid && (!full || ren);

  cr_kme_fifo_ptr #(.DEPTH(DEPTH)) u_wptr (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .inc   (wen_ok),
    .ptr   (wptr)
  );

  cr_kme_fifo_ptr #(.DEPTH(DEPTH)) u_rptr (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .inc   (ren),
    .ptr   (rptr)
  );

  // Storage is intentionally not reset; validity is tracked by used_reg only.
  always_ff @(posedge clk) begin
    if (wen_ok && !rst && !clear) begin
      mem[wptr] <= fifo_in;
    end
  end

  always_comb begin
    used_next = used_reg;
    case ({wen_ok, ren})
      2'b10:   used_next = used_reg + CW'(1);
      2'b01:   used_next = used_reg - CW'(1);
      default: used_next = used_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      used_reg      <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      used_reg      <= used_next;
      overflow_reg  <= fifo_in_valid && full && !ren;
      underflow_reg <= fifo_out_ack && empty;
    end
  end

  assign used_slots     = used_reg;
  assign free_slots     = CW'(DEPTH) - used_reg;
  assign fifo_out_valid = !empty;
  assign fifo_out       = empty ? '0 : mem[rptr];
  // Depends only on registered count and the override, never on fifo_in_valid.
  assign fifo_in_stall  = (free_slots <= CW'(STALL_THRESH)) || fifo_in_stall_override;
  assign fifo_overflow  = overflow_reg;
  assign fifo_underflow = underflow_reg;

`ifdef CR_KME_FIFO_WMARK_EN
  logic [CW-1:0] max_used_reg;

  // Tracks the registered count, so it lags used_slots by one cycle.
  // max_used_clr reloads from the current occupancy rather than zero.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      max_used_reg <= '0;
    end else if (max_used_clr) begin
      max_used_reg <= used_reg;
    end else if (used_reg > max_used_reg) begin
      max_used_reg <= used_reg;
    end
  end

  assign max_used = max_used_reg;
`endif

endmodule
